mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
//  MEM-stage engine on the consuming side of the EX/MEM pipeline register. Takes the decoded EX/MEM fields
//  and runs the data-memory transaction over a req/ack handshake. Drives stall_EX back to the EX/MEM register
//  while the access is outstanding, then loads the MEM/WB register. Sits between EX/MEM and the write-back stage.
// PARAMETERS
//  ADDR_W    16  data-memory address width
//  DATA_W    16  data/result width
//  MAX_WAIT  15  negedges allowed with dmem_req high and no ack before abort (1..255)
// PORTS
//  clk                  in   1       clock; all registers update on negedge clk
//  resetn               in   1       asynchronous, active-low reset
//  in_Validity          in   1       EX/MEM entry valid (0 = bubble)
//  in_M_addr            in   ADDR_W  load/store address
//  in_ANS_LHI_PC1       in   DATA_W  non-memory result (ALU/LHI/PC+1)
//  in_Data_in           in   DATA_W  store data
//  in_RDest             in   3       destination register
//  in_mem_ans           in   1       1 = load; write-back value is memory read data
//  in_W_mem             in   1       1 = store
//  in_W_reg             in   1       register write enable
//  in_stop              in   1       halt marker, passed through
//  in_pc                in   16      instruction PC, passed through
//  dmem_req             out  1       memory request, held until ack
//  dmem_we              out  1       1 = write, valid with dmem_req
//  dmem_addr            out  ADDR_W  request address
//  dmem_wdata           out  DATA_W  write data
//  dmem_rdata           in   DATA_W  read data, valid with dmem_ack
//  dmem_ack             in   1       one-cycle completion strobe
//  stall_EX             out  1       hold EX/MEM register (combinational)
//  out_WB_data          out  DATA_W  MEM/WB write-back value
//  out_RDest            out  3       MEM/WB destination
//  out_W_reg            out  1       MEM/WB register write enable
//  out_stop             out  1       MEM/WB halt marker
//  out_pc               out  16      MEM/WB PC
//  out_Validity_MEM_WB  out  1       MEM/WB valid
//  out_mem_err          out  1       sticky timeout flag
//  fwd_valid            out  1       forwarding bus valid (MEM_FWD_EN only)
//  fwd_rdest            out  3       forwarding destination
//  fwd_data             out  DATA_W  forwarding value
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, every output 0 (including out_mem_err), applied immediately.
//    An access in flight is abandoned and dmem_req drops asynchronously.
//  mem_op = in_Validity & (in_mem_ans | in_W_mem).
//  FSM IDLE:
//    - mem_op=1: dmem_req=1 combinationally. addr = in_M_addr; we = in_W_mem; wdata = in_Data_in.
//    - If dmem_ack=1 in the same cycle, complete now (zero stall).
//    - Otherwise go ACCESS on the negedge.
//  FSM ACCESS: hold dmem_req and the request fields; counter +1 per negedge.
//    - dmem_ack=1: complete and return to IDLE.
//    - Counter reaches MAX_WAIT with no ack: abort, return to IDLE, set out_mem_err=1.
//  stall_EX = mem_op & ~dmem_ack while IDLE; = ~dmem_ack while ACCESS. It deasserts in the ack cycle,
//    so EX/MEM and MEM/WB advance on the same negedge. EX/MEM inputs are stable while stalled.
//  Complete (negedge):
//    - out_WB_data = in_mem_ans ? dmem_rdata : in_ANS_LHI_PC1.
//    - RDest, W_reg, stop and pc copied from the inputs; out_Validity_MEM_WB=1.
//  Abort: same as complete, except out_W_reg=0 and out_WB_data=0. Counter clears on every return to IDLE.
//  Valid non-memory entry: MEM/WB loads on the next negedge (1-cycle latency); no request, no stall.
//  Bubble (in_Validity=0):
//    - out_Validity_MEM_WB=0, out_RDest=0, out_W_reg=0, out_stop=0.
//    - out_WB_data and out_pc hold.
//  dmem_ack while no request is outstanding: ignored.
//  Simultaneous ack and timeout: ack wins, no error.
//  Store: out_W_reg follows in_W_reg (normally 0).
// CONFIGURATION
//  MEM_FWD_EN defined:
//    - fwd_valid = out_Validity_MEM_WB & out_W_reg.
//    - fwd_rdest = out_RDest; fwd_data = out_WB_data.
//  MEM_FWD_EN undefined: fwd_* tied to 0 and no forwarding logic is built.
// TESTING
//  ALU op: valid=1, mem_ans=0, W_reg=1, RDest=3, ANS=0x1234 -> next negedge WB_data=0x1234, RDest=3,
//    W_reg=1; stall_EX stays 0.
//  Load: addr 0x0040, ack on 3rd cycle with rdata 0xBEEF -> req high 3 cycles, stall_EX high 2 cycles,
//    WB_data=0xBEEF.
//  Store: W_mem=1, addr 0x0010, Data_in 0x5A5A, ack same cycle -> we=1, wdata=0x5A5A, stall_EX 0,
//    out_W_reg=0.
//  Timeout: load, ack never, MAX_WAIT=15 -> req drops after 15 negedges, out_mem_err=1 (sticky),
//    out_W_reg=0, stall_EX released.
//  Reset mid-access: resetn low in ACCESS -> dmem_req, stall_EX and all outputs 0 at once;
//    the first load after release behaves normally.
//  Bubble + forwarding (MEM_FWD_EN): valid=0, W_reg=1 -> out_W_reg=0, RDest=0, Validity=0, fwd_valid=0;
//    without the macro, fwd_* = 0 for every test.

Source files
------------

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory engine between EX/MEM and MEM/WB; `define MEM_FWD_EN adds a forwarding bus.
// Latency: 1 negedge for non-memory entries; memory ops load MEM/WB on the ack negedge (same-cycle ack = no stall).
// Backpressure: stall_EX holds EX/MEM until dmem_ack or a MAX_WAIT timeout abort.
module mem_stage_access #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_Validity,
  input  logic [ADDR_W-1:0] in_M_addr,
  input  logic [DATA_W-1:0] in_ANS_LHI_PC1,
  input  logic [DATA_W-1:0] in_Data_in,
  input  logic [2:0]        in_RDest,
  input  logic              in_mem_ans,
  input  logic              in_W_mem,
  input  logic              in_W_reg,
  input  logic              in_stop,
  input  logic [15:0]       in_pc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_EX,
  output logic [DATA_W-1:0] out_WB_data,
  output logic [2:0]        out_RDest,
  output logic              out_W_reg,
  output logic              out_stop,
  output logic [15:0]       out_pc,
  output logic              out_Validity_MEM_WB,
  output logic              out_mem_err,
  output logic              fwd_valid,
  output logic [2:0]        fwd_rdest,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] wb_dat;
    logic [2:0]        rdest;
    logic              w_reg;
    logic              stop;
    logic [15:0]       pc;
  } memwb_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_op;
  logic       req_c, stall_c;
  logic       done_vld, abort_vld;
  logic       mem_err;
  memwb_t     mw, mw_nxt;

  assign mem_op = in_Validity & (in_mem_ans | in_W_mem);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_c        = 1'b0;
    stall_c      = 1'b0;
    done_vld     = 1'b0;
    abort_vld    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          req_c = 1'b1;
          if (dmem_ack) begin
            done_vld = 1'b1;
          end else begin
            stall_c      = 1'b1;
            state_nxt    = ACCESS;
            wait_cnt_nxt = 8'd0;
          end
        end
      end
      ACCESS: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          done_vld     = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == WAIT_LIM - 8'd1) begin
          // Abort cycle is the entry's last: release EX/MEM so it is not re-issued.
          abort_vld    = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else begin
          stall_c      = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must kill the request and stall immediately, not at the next edge.
  assign dmem_req   = resetn & req_c;
  assign stall_EX   = resetn & stall_c;
  assign dmem_we    = dmem_req & in_W_mem;
  assign dmem_addr  = dmem_req ? in_M_addr : '0;
  assign dmem_wdata = dmem_req ? in_Data_in : '0;

  always_comb begin
    mw_nxt = mw;
    if (done_vld) begin
      mw_nxt.vld    = 1'b1;
      mw_nxt.wb_dat = in_mem_ans ? dmem_rdata : in_ANS_LHI_PC1;
      mw_nxt.rdest  = in_RDest;
      mw_nxt.w_reg  = in_W_reg;
      mw_nxt.stop   = in_stop;
      mw_nxt.pc     = in_pc;
    end else if (abort_vld) begin
      mw_nxt.vld    = 1'b1;
      mw_nxt.wb_dat = '0;
      mw_nxt.rdest  = in_RDest;
      mw_nxt.w_reg  = 1'b0;
      mw_nxt.stop   = in_stop;
      mw_nxt.pc     = in_pc;
    end else if (in_Validity & ~mem_op) begin
      mw_nxt.vld    = 1'b1;
      mw_nxt.wb_dat = in_ANS_LHI_PC1;
      mw_nxt.rdest  = in_RDest;
      mw_nxt.w_reg  = in_W_reg;
      mw_nxt.stop   = in_stop;
      mw_nxt.pc     = in_pc;
    end else begin
      // Bubbles and stalled cycles: invalidate control, keep data and pc.
      mw_nxt.vld    = 1'b0;
      mw_nxt.rdest  = 3'd0;
      mw_nxt.w_reg  = 1'b0;
      mw_nxt.stop   = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      mw       <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mw       <= mw_nxt;
      mem_err  <= mem_err | abort_vld;
    end
  end

  assign out_WB_data         = mw.wb_dat;
  assign out_RDest           = mw.rdest;
  assign out_W_reg           = mw.w_reg;
  assign out_stop            = mw.stop;
  assign out_pc              = mw.pc;
  assign out_Validity_MEM_WB = mw.vld;
  assign out_mem_err         = mem_err;

`ifdef MEM_FWD_EN
  assign fwd_valid = mw.vld & mw.w_reg;
  assign fwd_rdest = mw.rdest;
  assign fwd_data  = mw.wb_dat;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rdest = 3'd0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: vector table driven through a per-cycle loop, MEM/WB checked against a scoreboard.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_Validity = 1'b0;
  logic [15:0] in_M_addr = '0;
  logic [15:0] in_ANS_LHI_PC1 = '0;
  logic [15:0] in_Data_in = '0;
  logic [2:0]  in_RDest = '0;
  logic        in_mem_ans = 1'b0;
  logic        in_W_mem = 1'b0;
  logic        in_W_reg = 1'b0;
  logic        in_stop = 1'b0;
  logic [15:0] in_pc = '0;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall_EX;
  logic [15:0] out_WB_data;
  logic [2:0]  out_RDest;
  logic        out_W_reg, out_stop;
  logic [15:0] out_pc;
  logic        out_Validity_MEM_WB, out_mem_err;
  logic        fwd_valid;
  logic [2:0]  fwd_rdest;
  logic [15:0] fwd_data;

  mem_stage_access #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .resetn(resetn), .in_Validity(in_Validity), .in_M_addr(in_M_addr),
    .in_ANS_LHI_PC1(in_ANS_LHI_PC1), .in_Data_in(in_Data_in), .in_RDest(in_RDest),
    .in_mem_ans(in_mem_ans), .in_W_mem(in_W_mem), .in_W_reg(in_W_reg), .in_stop(in_stop),
    .in_pc(in_pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_EX(stall_EX),
    .out_WB_data(out_WB_data), .out_RDest(out_RDest), .out_W_reg(out_W_reg), .out_stop(out_stop),
    .out_pc(out_pc), .out_Validity_MEM_WB(out_Validity_MEM_WB), .out_mem_err(out_mem_err),
    .fwd_valid(fwd_valid), .fwd_rdest(fwd_rdest), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, mem_ans, w_mem, w_reg, stop;
    logic [2:0]  rdest;
    logic [15:0] addr, ans, din, pc, rdata;
    int          ack_at;
    logic [15:0] exp_wb;
    logic        exp_wreg;
    int          exp_req, exp_stall;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] wb;
    logic [2:0]  rdest;
    logic        wreg, stop;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_wb = '0;
  logic [15:0] last_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (out_Validity_MEM_WB) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=valid_output required=none");
      end else begin
        e = sb.pop_front();
        chk("wb_data", out_WB_data, e.wb);
        chk("rdest", out_RDest, e.rdest);
        chk("w_reg", out_W_reg, e.wreg);
        chk("stop", out_stop, e.stop);
        chk("pc", out_pc, e.pc);
`ifdef MEM_FWD_EN
        chk("fwd_valid", fwd_valid, e.wreg);
        chk("fwd_data", fwd_data, e.wb);
        chk("fwd_rdest", fwd_rdest, e.rdest);
`else
        chk("fwd_valid", fwd_valid, 0);
        chk("fwd_data", fwd_data, 0);
`endif
      end
    end
  endtask

  task automatic drive(input vec_t v);
    in_Validity    = v.valid;
    in_mem_ans     = v.mem_ans;
    in_W_mem       = v.w_mem;
    in_W_reg       = v.w_reg;
    in_stop        = v.stop;
    in_RDest       = v.rdest;
    in_M_addr      = v.addr;
    in_ANS_LHI_PC1 = v.ans;
    in_Data_in     = v.din;
    in_pc          = v.pc;
  endtask

  // Called just after a negedge; runs the entry until stall_EX drops, then returns just after that negedge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    bit   finished = 0;
    drive(v);
    if (v.valid) begin
      e.wb = v.exp_wb; e.rdest = v.rdest; e.wreg = v.exp_wreg; e.stop = v.stop; e.pc = v.pc;
      sb.push_back(e);
      last_wb = v.exp_wb;
      last_pc = v.pc;
    end
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      dmem_ack   = (cyc == v.ack_at);
      dmem_rdata = (cyc == v.ack_at) ? v.rdata : 16'hDEAD;
      #1;
      if (dmem_req) req_cnt++;
      if (stall_EX) stall_cnt++;
      if (cyc == 0 && dmem_req) begin
        chk({tag, "_addr"}, dmem_addr, v.addr);
        chk({tag, "_we"}, dmem_we, v.w_mem);
        if (v.w_mem) chk({tag, "_wdata"}, dmem_wdata, v.din);
      end
      finished = !stall_EX;
      @(negedge clk);
      #2;
      dmem_ack = 1'b0;
      check_out();
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL %s_stall_bound actual=still_stalled required=release", tag);
    end
    chk({tag, "_req_cycles"}, req_cnt, v.exp_req);
    chk({tag, "_stall_cycles"}, stall_cnt, v.exp_stall);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    chk({tag, "_mem_err"}, out_mem_err, v.exp_err);
  endtask

  initial begin
    //          valid ma wm wr st rd    addr      ans       din       pc        rdata     ack  exp_wb    ewr rq  st  err
    vecs[0] = '{1'b1, 0, 0, 1, 0, 3'd3, 16'h0000, 16'h1234, 16'h0000, 16'h0100, 16'h0000, 0,   16'h1234, 1, 0,  0,  0};
    vecs[1] = '{1'b1, 1, 0, 1, 0, 3'd5, 16'h0040, 16'h0000, 16'h0000, 16'h0101, 16'hBEEF, 2,   16'hBEEF, 1, 3,  2,  0};
    vecs[2] = '{1'b1, 0, 1, 0, 0, 3'd0, 16'h0010, 16'h0777, 16'h5A5A, 16'h0102, 16'h0000, 0,   16'h0777, 0, 1,  0,  0};
    vecs[3] = '{1'b0, 0, 0, 1, 1, 3'd6, 16'h0000, 16'h9999, 16'h0000, 16'h0103, 16'h0000, 255, 16'h0000, 0, 0,  0,  0};
    vecs[4] = '{1'b1, 1, 0, 1, 0, 3'd1, 16'h0044, 16'h0000, 16'h0000, 16'h0104, 16'h1111, 0,   16'h1111, 1, 1,  0,  0};
    vecs[5] = '{1'b1, 1, 0, 1, 0, 3'd2, 16'h0048, 16'h0000, 16'h0000, 16'h0105, 16'hCAFE, 15,  16'hCAFE, 1, 16, 15, 0};
    vecs[6] = '{1'b1, 1, 0, 1, 1, 3'd4, 16'h004C, 16'h0000, 16'h0000, 16'h0106, 16'h0000, 255, 16'h0000, 0, 16, 15, 1};
    vecs[7] = '{1'b1, 0, 0, 1, 1, 3'd7, 16'h0000, 16'hABCD, 16'h0000, 16'h0107, 16'h0000, 0,   16'hABCD, 1, 0,  0,  1};

    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_EX, 0);
    chk("rst_valid", out_Validity_MEM_WB, 0);
    chk("rst_wb", out_WB_data, 0);
    chk("rst_err", out_mem_err, 0);
    chk("rst_fwd", fwd_valid, 0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
      if (!vecs[i].valid) begin
        chk("bubble_valid", out_Validity_MEM_WB, 0);
        chk("bubble_rdest", out_RDest, 0);
        chk("bubble_wreg", out_W_reg, 0);
        chk("bubble_stop", out_stop, 0);
        chk("bubble_wb_hold", out_WB_data, last_wb);
        chk("bubble_pc_hold", out_pc, last_pc);
        chk("bubble_fwd", fwd_valid, 0);
      end
    end

    // Reset in the middle of an outstanding load.
    drive(vecs[6]);
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("mid_req_before", dmem_req, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall_EX, 0);
    chk("mid_rst_valid", out_Validity_MEM_WB, 0);
    chk("mid_rst_wb", out_WB_data, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_err", out_mem_err, 0);
    sb.delete();
    @(negedge clk);
    #2;
    resetn = 1'b1;
    apply(vecs[1], "post_rst_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
